// File: rtl/div_unit_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_iter_if
// Brief    : Request/result bundle between the control FSM and the divider.
// Revision : 1.0 - initial release
// ============================================================================
interface div_unit_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/div_unit_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_iter
// Brief    : Iterative restoring DIV/DIVU unit feeding HI (remainder) and
//            LO (quotient). Define DIV_EARLY_OUT_EN to skip the iteration
//            loop for a zero divisor or when |dividend| < |divisor|.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit_iter #(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    div_unit_iter_if.slave   bus
);
    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz_op;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dsr;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_q_out;
    logic [WIDTH-1:0]   r_r_out;
    logic               r_dz;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic               w_early;

    // The most negative value negates to itself, which reads correctly as unsigned.
    assign w_abs_a = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign w_abs_b = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (bus.divisor == '0) || (w_abs_a < w_abs_b);
`else
    assign w_early = 1'b0;
`endif

    // Trial value is one bit wider: the shifted partial remainder can exceed WIDTH bits.
    assign w_trial = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_trial >= {1'b0, r_dsr});
    assign w_diff  = w_trial[WIDTH-1:0] - r_dsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = w_early ? ST_FIX : ST_CALC;
            ST_CALC: if (r_cnt == c_LAST) w_next = ST_FIX;
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz_op <= 1'b0;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_q_out <= '0;
            r_r_out <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_neg_q <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg_r <= bus.is_signed & bus.dividend[WIDTH-1];
                        r_dz_op <= (bus.divisor == '0);
                        r_dvd   <= bus.dividend;
                        r_dsr   <= w_abs_b;
                        r_cnt   <= '0;
                        // An early exit lands in FIX with quotient 0 and |dividend| as remainder.
                        if (w_early) begin
                            r_rem <= w_abs_a;
                            r_quo <= '0;
                        end else begin
                            r_rem <= '0;
                            r_quo <= w_abs_a;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_ge ? w_diff : w_trial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_FIX: begin
                    r_dz <= r_dz_op;
                    if (r_dz_op) begin
                        r_q_out <= '1;
                        r_r_out <= r_dvd;
                    end else begin
                        r_q_out <= r_neg_q ? -r_quo : r_quo;
                        r_r_out <= r_neg_r ? -r_rem : r_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.quotient  = r_q_out;
    assign bus.remainder = r_r_out;
    assign bus.div_zero  = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_div_unit_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit_iter
// Brief    : Directed self-checking bench for div_unit_iter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_dbl    = 0;
    logic r_prev_done = 1'b0;
    logic [31:0] prev_q = '0;
    logic [31:0] prev_r = '0;

    always #5 clk = ~clk;

    div_unit_iter_if #(.WIDTH(32)) bus ();

    div_unit_iter #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.done && r_prev_done) n_dbl <= n_dbl + 1;
        r_prev_done <= bus.done;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] aa;
        logic [31:0] ab;
        aa = (sgn && a[31]) ? -a : a;
        ab = (sgn && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'd0 || aa < ab) return 2;
`endif
        if (aa == ab) return 34;
        return 34;
    endfunction

    // Starts in the current cycle (cycle 0); returns in the cycle after done.
    task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic ez, input logic inj);
        int n;
        int lat;
        int holds;
        int busy_err;
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1; lat = 0; holds = 0; busy_err = 0;
        while (n <= 100 && lat == 0) begin
            if (!bus.busy) busy_err++;
            if (bus.done) lat = n;
            else if (bus.quotient !== prev_q || bus.remainder !== prev_r) holds++;
            if (n == 1) begin
                bus.dividend = ~a;
                bus.divisor  = b + 32'd3;
                bus.is_signed = ~sgn;
            end
            if (inj && n == 10) begin
                bus.start     = 1'b1;
                bus.is_signed = 1'b0;
                bus.dividend  = 32'd50;
                bus.divisor   = 32'd5;
            end
            if (inj && n == 11) bus.start = 1'b0;
            if (lat == 0) begin
                @(negedge clk);
                n++;
            end
        end
        bus.start = 1'b0;
        chk({tag, "_lat"},  lat, exp_lat(sgn, a, b));
        chk({tag, "_q"},    bus.quotient, eq);
        chk({tag, "_r"},    bus.remainder, er);
        chk({tag, "_dz"},   {31'd0, bus.div_zero}, {31'd0, ez});
        chk({tag, "_hold"}, holds, 0);
        chk({tag, "_busy"}, busy_err, 0);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, bus.done}, 32'd0);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        int nd;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_q",    bus.quotient, 32'd0);
        chk("rst_r",    bus.remainder, 32'd0);
        chk("rst_dz",   {31'd0, bus.div_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("divu_100_7",  1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 1'b0);
        do_op("div_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0);
        do_op("div_7_m2",    1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 1'b0);
        do_op("div_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b0);
        do_op("divu_max_1",  1'b0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b0);
        do_op("divu_5_0",    1'b0, 32'd5,        32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1'b0);
        do_op("div_m5_0",    1'b1, 32'hFFFFFFFB, 32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 1'b0);
        do_op("divu_3_10",   1'b0, 32'd3,        32'd10,         32'd0,          32'd3,          1'b0, 1'b0);
        do_op("div_m3_10",   1'b1, 32'hFFFFFFFD, 32'd10,         32'd0,          32'hFFFFFFFD,   1'b0, 1'b0);
        do_op("div_big",     1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF,   32'd0,          32'hFFFFFFFE,   1'b0, 1'b0);
        do_op("inj_100_7",   1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 1'b1);

        nd = 0;
        for (int i = 0; i < 40; i++) begin
            nd += int'(bus.done);
            @(negedge clk);
        end
        chk("inj_no_extra_done", nd, 0);
        chk("inj_q_held", bus.quotient, 32'd14);

        // Abort: start in cycle 0, reset during cycle 20.
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        nd = 0;
        for (int i = 1; i < 20; i++) begin
            nd += int'(bus.done);
            @(negedge clk);
        end
        nd += int'(bus.done);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_q",    bus.quotient, 32'd0);
        chk("abort_r",    bus.remainder, 32'd0);
        chk("abort_dz",   {31'd0, bus.div_zero}, 32'd0);
        chk("abort_no_done", nd, 0);
        @(negedge clk);
        prev_q = '0;
        prev_r = '0;
        do_op("after_abort", 1'b1, 32'hFFFFFC18, 32'd3, 32'hFFFFFEB3, 32'hFFFFFFFF, 1'b0, 1'b0);
        do_op("b2b_2",       1'b0, 32'd81,       32'd9, 32'd9,        32'd0,        1'b0, 1'b0);

        chk("no_double_done", n_dbl, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
